axil_stim_gen: RTL and testbench
================================

// Module: axil_stim_gen
// PURPOSE
// - Self-running AXI4-Lite master that drives a fixed write-then-readback test sequence into a slave port.
// - Used as a stimulus source in simulation tops that wrap slave register blocks.
// - No host interface: starts on its own after reset, finishes, then idles.
// - Readback mismatches are counted internally and exposed as hierarchical debug signals.
// PARAMETERS
// - DATA_WIDTH    32          AXI data width (32 only; wstrb = DATA_WIDTH/8)
// - ADDR_WIDTH    32          AXI address width
// - BASE_ADDR     'h0         address of first register accessed
// - NUM_REGS      4           number of word registers written then read back (1..64)
// - START_DELAY   16          idle cycles after reset release before first transaction
// - TIMEOUT       1024        max cycles spent waiting in any handshake state
// PORTS
// - M_AXI_aclk     in   1             clock; all logic on rising edge
// - M_AXI_aresetn  in   1             asynchronous, active-low reset
// - M_AXI_awaddr   out  ADDR_WIDTH    write address
// - M_AXI_awprot   out  3             fixed 3'b000
// - M_AXI_awvalid  out  1             write address valid
// - M_AXI_awready  in   1             write address ready
// - M_AXI_wdata    out  DATA_WIDTH    write data
// - M_AXI_wstrb    out  DATA_WIDTH/8  fixed all ones
// - M_AXI_wvalid   out  1             write data valid
// - M_AXI_wready   in   1             write data ready
// - M_AXI_bresp    in   2             write response
// - M_AXI_bvalid   in   1             write response valid
// - M_AXI_bready   out  1             write response ready
// - M_AXI_araddr   out  ADDR_WIDTH    read address
// - M_AXI_arprot   out  3             fixed 3'b000
// - M_AXI_arvalid  out  1             read address valid
// - M_AXI_arready  in   1             read address ready
// - M_AXI_rdata    in   DATA_WIDTH    read data
// - M_AXI_rresp    in   2             read response
// - M_AXI_rvalid   in   1             read data valid
// - M_AXI_rready   out  1             read data ready
// BEHAVIOUR
// - Reset: all valid/ready outputs 0, addr/data 0, state WAIT, idx 0, delay counter 0, err_cnt 0, done 0.
// - Outputs are registered; no combinational path from any input to any output.
// - Sequence: WAIT (START_DELAY cycles) -> for i=0..NUM_REGS-1 write -> for i=0..NUM_REGS-1 read -> DONE.
// - Address = BASE_ADDR + 4*i. Write data = 32'hA5A5_0000 + i. Expected read data is the same value.
// - One outstanding transaction at a time.
// - WR_REQ: assert awvalid and wvalid together. Each drops on the cycle after its own ready is sampled high.
//   Handshakes may complete in either order or in the same cycle.
// - Move to WR_RESP when both handshakes are done. bready=1 until bvalid is sampled.
//   bresp!=OKAY increments err_cnt. Then idx++, or start the read phase after the last write.
// - RD_REQ: arvalid held until arready. RD_RESP: rready=1 until rvalid.
//   rdata!=expected or rresp!=OKAY increments err_cnt.
// - Address/data are stable while the corresponding valid is high; valid never drops before its handshake.
// - Timeout: TIMEOUT cycles in any handshake state -> err_cnt++, drop all valids, go to DONE.
// - DONE: all valids/readies 0; done=1; stays until reset.
// - err_cnt is 8 bits and saturates at 255.
// - Reset mid-transaction: outputs clear immediately (async). After release the whole sequence restarts from idx 0.
// STRUCTURE
// - Shared pkg axil_stim_pkg: state enum (WAIT, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE) and RESP_OKAY=2'b00.
// - Single module, no sub-modules; the expected-data function lives in the package.
// TESTING
// - Zero-wait slave RAM, defaults: 4 writes (0x0..0xC, A5A50000..3), then 4 reads. err_cnt=0, done=1,
//   ~30 cycles after the delay.
// - Slave gives awready 3 cycles before wready, and vice versa. Exactly one AW and one W beat per write;
//   data is stable while valid is high.
// - Slave corrupts the read of 0x8 (returns 0). err_cnt=1 at done.
// - Slave returns bresp=SLVERR on the first write. err_cnt=1; the sequence still completes.
// - Slave never asserts arready. After TIMEOUT cycles: err_cnt=1, done=1, arvalid=0.
// - Assert aresetn low during the 2nd write. All valids drop at once; after release the bench sees
//   the first write again at 0x0.

Source files
------------

// File: rtl/axil_stim_pkg.sv
// Shared types and helpers for the AXI4-Lite stimulus generator.
//   state_t   : sequencer states
//   RESP_OKAY : AXI OKAY response code
//   exp_data  : write/readback pattern for register index idx
//   sat_inc8  : 8-bit saturating increment for the error counter
package axil_stim_pkg;

    typedef enum logic [2:0] {
        WAIT    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam logic [1:0]  RESP_OKAY = 2'b00;
    localparam int unsigned IDX_W     = 6;
    localparam logic [31:0] DATA_SEED = 32'hA5A5_0000;

    // Pattern written to (and expected back from) register idx
    function automatic logic [31:0] exp_data(input logic [IDX_W-1:0] idx);
        return DATA_SEED + 32'(idx);
    endfunction

    // Error counter sticks at its maximum
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/axil_stim_gen.sv
// Self-running AXI4-Lite master: after reset and a start delay it writes
// NUM_REGS words starting at BASE_ADDR, reads them back, then idles in DONE.
// Readback/response errors are counted in r_err_cnt; r_done flags completion.
// Ports:
//   M_AXI_aclk / M_AXI_aresetn : clock, async active-low reset
//   M_AXI_aw* / M_AXI_w*       : write address / data channels (master side)
//   M_AXI_b*                   : write response channel
//   M_AXI_ar* / M_AXI_r*       : read address / data channels
module axil_stim_gen
    import axil_stim_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int unsigned           NUM_REGS    = 4,
    parameter int unsigned           START_DELAY = 16,
    parameter int unsigned           TIMEOUT     = 1024
) (
    input  logic                      M_AXI_aclk,
    input  logic                      M_AXI_aresetn,
    output logic [ADDR_WIDTH-1:0]     M_AXI_awaddr,
    output logic [2:0]                M_AXI_awprot,
    output logic                      M_AXI_awvalid,
    input  logic                      M_AXI_awready,
    output logic [DATA_WIDTH-1:0]     M_AXI_wdata,
    output logic [DATA_WIDTH/8-1:0]   M_AXI_wstrb,
    output logic                      M_AXI_wvalid,
    input  logic                      M_AXI_wready,
    input  logic [1:0]                M_AXI_bresp,
    input  logic                      M_AXI_bvalid,
    output logic                      M_AXI_bready,
    output logic [ADDR_WIDTH-1:0]     M_AXI_araddr,
    output logic [2:0]                M_AXI_arprot,
    output logic                      M_AXI_arvalid,
    input  logic                      M_AXI_arready,
    input  logic [DATA_WIDTH-1:0]     M_AXI_rdata,
    input  logic [1:0]                M_AXI_rresp,
    input  logic                      M_AXI_rvalid,
    output logic                      M_AXI_rready
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned DLY_W  = $clog2(START_DELAY + 2);
    localparam int unsigned TMO_W  = $clog2(TIMEOUT + 2);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    // Byte address of word register idx
    function automatic logic [ADDR_WIDTH-1:0] reg_addr(input logic [IDX_W-1:0] idx);
        return BASE_ADDR + ADDR_WIDTH'({idx, 2'b00});
    endfunction

    state_t                  r_state,   w_state;
    logic [IDX_W-1:0]        r_idx,     w_idx;
    logic [DLY_W-1:0]        r_dly_cnt, w_dly_cnt;
    logic [TMO_W-1:0]        r_tmo_cnt, w_tmo_cnt;
    logic [7:0]              r_err_cnt, w_err_cnt;
    logic                    r_done,    w_done;
    logic                    r_awvalid, w_awvalid;
    logic                    r_wvalid,  w_wvalid;
    logic                    r_bready,  w_bready;
    logic                    r_arvalid, w_arvalid;
    logic                    r_rready,  w_rready;
    logic [ADDR_WIDTH-1:0]   r_awaddr,  w_awaddr;
    logic [DATA_WIDTH-1:0]   r_wdata,   w_wdata;
    logic [ADDR_WIDTH-1:0]   r_araddr,  w_araddr;

    logic                    w_err_inc;
    logic                    w_timeout;
    logic                    w_aw_ok;
    logic                    w_w_ok;
    logic                    w_tmo_hit;
    logic                    w_in_hs;
    logic                    w_dly_hit;

    // A channel is finished once its valid has dropped or its ready is seen now
    assign w_aw_ok   = !r_awvalid || M_AXI_awready;
    assign w_w_ok    = !r_wvalid  || M_AXI_wready;
    assign w_tmo_hit = (32'(r_tmo_cnt) + 32'd1) >= TIMEOUT;
    assign w_dly_hit = (32'(r_dly_cnt) + 32'd1) >= START_DELAY;
    assign w_in_hs   = (r_state == WR_REQ) || (r_state == WR_RESP) ||
                       (r_state == RD_REQ) || (r_state == RD_RESP);

    // Next-state and next-output logic
    always_comb begin
        w_state   = r_state;
        w_idx     = r_idx;
        w_dly_cnt = r_dly_cnt;
        w_tmo_cnt = r_tmo_cnt;
        w_err_cnt = r_err_cnt;
        w_done    = r_done;
        w_awvalid = r_awvalid;
        w_wvalid  = r_wvalid;
        w_bready  = r_bready;
        w_arvalid = r_arvalid;
        w_rready  = r_rready;
        w_awaddr  = r_awaddr;
        w_wdata   = r_wdata;
        w_araddr  = r_araddr;
        w_err_inc = 1'b0;
        w_timeout = 1'b0;

        unique case (r_state)
            WAIT: begin
                if (w_dly_hit) begin
                    w_state   = WR_REQ;
                    w_awvalid = 1'b1;
                    w_wvalid  = 1'b1;
                    w_awaddr  = reg_addr('0);
                    w_wdata   = DATA_WIDTH'(exp_data('0));
                end else begin
                    w_dly_cnt = r_dly_cnt + DLY_W'(1);
                end
            end

            WR_REQ: begin
                if (M_AXI_awready) w_awvalid = 1'b0;
                if (M_AXI_wready)  w_wvalid  = 1'b0;
                if (w_aw_ok && w_w_ok) begin
                    w_state  = WR_RESP;
                    w_bready = 1'b1;
                end else if (w_tmo_hit) begin
                    w_timeout = 1'b1;
                end
            end

            WR_RESP: begin
                if (M_AXI_bvalid) begin
                    w_bready = 1'b0;
                    if (M_AXI_bresp != RESP_OKAY) w_err_inc = 1'b1;
                    if (r_idx == LAST_IDX) begin
                        w_idx     = '0;
                        w_state   = RD_REQ;
                        w_arvalid = 1'b1;
                        w_araddr  = reg_addr('0);
                    end else begin
                        w_idx     = r_idx + IDX_W'(1);
                        w_state   = WR_REQ;
                        w_awvalid = 1'b1;
                        w_wvalid  = 1'b1;
                        w_awaddr  = reg_addr(r_idx + IDX_W'(1));
                        w_wdata   = DATA_WIDTH'(exp_data(r_idx + IDX_W'(1)));
                    end
                end else if (w_tmo_hit) begin
                    w_timeout = 1'b1;
                end
            end

            RD_REQ: begin
                if (M_AXI_arready) begin
                    w_arvalid = 1'b0;
                    w_rready  = 1'b1;
                    w_state   = RD_RESP;
                end else if (w_tmo_hit) begin
                    w_timeout = 1'b1;
                end
            end

            RD_RESP: begin
                if (M_AXI_rvalid) begin
                    w_rready = 1'b0;
                    if ((M_AXI_rdata != DATA_WIDTH'(exp_data(r_idx))) ||
                        (M_AXI_rresp != RESP_OKAY)) begin
                        w_err_inc = 1'b1;
                    end
                    if (r_idx == LAST_IDX) begin
                        w_state = DONE;
                        w_done  = 1'b1;
                    end else begin
                        w_idx     = r_idx + IDX_W'(1);
                        w_state   = RD_REQ;
                        w_arvalid = 1'b1;
                        w_araddr  = reg_addr(r_idx + IDX_W'(1));
                    end
                end else if (w_tmo_hit) begin
                    w_timeout = 1'b1;
                end
            end

            DONE: begin
                w_done = 1'b1;
            end

            default: begin
                w_state = WAIT;
            end
        endcase

        // Stalled handshake: abandon the sequence with every valid/ready low
        if (w_timeout) begin
            w_err_inc = 1'b1;
            w_awvalid = 1'b0;
            w_wvalid  = 1'b0;
            w_bready  = 1'b0;
            w_arvalid = 1'b0;
            w_rready  = 1'b0;
            w_state   = DONE;
            w_done    = 1'b1;
        end

        if (w_err_inc) w_err_cnt = sat_inc8(r_err_cnt);

        // Timeout counter measures time spent in the current handshake state
        if (w_state != r_state) begin
            w_tmo_cnt = '0;
        end else if (w_in_hs) begin
            w_tmo_cnt = r_tmo_cnt + TMO_W'(1);
        end

        // Completion is sticky until reset
        if (r_done) w_state = DONE;
    end

    // State and output registers
    always_ff @(posedge M_AXI_aclk or negedge M_AXI_aresetn) begin
        if (!M_AXI_aresetn) begin
            r_state   <= WAIT;
            r_idx     <= '0;
            r_dly_cnt <= '0;
            r_tmo_cnt <= '0;
            r_err_cnt <= '0;
            r_done    <= 1'b0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_araddr  <= '0;
        end else begin
            r_state   <= w_state;
            r_idx     <= w_idx;
            r_dly_cnt <= w_dly_cnt;
            r_tmo_cnt <= w_tmo_cnt;
            r_err_cnt <= w_err_cnt;
            r_done    <= w_done;
            r_awvalid <= w_awvalid;
            r_wvalid  <= w_wvalid;
            r_bready  <= w_bready;
            r_arvalid <= w_arvalid;
            r_rready  <= w_rready;
            r_awaddr  <= w_awaddr;
            r_wdata   <= w_wdata;
            r_araddr  <= w_araddr;
        end
    end

    assign M_AXI_awaddr  = r_awaddr;
    assign M_AXI_awprot  = 3'b000;
    assign M_AXI_awvalid = r_awvalid;
    assign M_AXI_wdata   = r_wdata;
    assign M_AXI_wstrb   = {STRB_W{1'b1}};
    assign M_AXI_wvalid  = r_wvalid;
    assign M_AXI_bready  = r_bready;
    assign M_AXI_araddr  = r_araddr;
    assign M_AXI_arprot  = 3'b000;
    assign M_AXI_arvalid = r_arvalid;
    assign M_AXI_rready  = r_rready;

endmodule

// File: tb/tb_axil_stim_gen.sv
// Bench for axil_stim_gen: a behavioural AXI4-Lite slave RAM with configurable
// ready latencies and error injection, a posedge protocol monitor, and a
// scoreboard that derives the expected transaction list and error count.
module tb_axil_stim_gen;
    import axil_stim_pkg::*;

    localparam int unsigned NREG = 4;
    localparam int unsigned SDLY = 16;
    localparam int unsigned TMO  = 1024;
    localparam logic [31:0] BASE = 32'h0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    always #5 clk = ~clk;

    axil_stim_gen #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .BASE_ADDR(BASE),
        .NUM_REGS(NREG), .START_DELAY(SDLY), .TIMEOUT(TMO)
    ) dut (
        .M_AXI_aclk(clk),        .M_AXI_aresetn(rst_n),
        .M_AXI_awaddr(awaddr),   .M_AXI_awprot(awprot),
        .M_AXI_awvalid(awvalid), .M_AXI_awready(awready),
        .M_AXI_wdata(wdata),     .M_AXI_wstrb(wstrb),
        .M_AXI_wvalid(wvalid),   .M_AXI_wready(wready),
        .M_AXI_bresp(bresp),     .M_AXI_bvalid(bvalid),
        .M_AXI_bready(bready),
        .M_AXI_araddr(araddr),   .M_AXI_arprot(arprot),
        .M_AXI_arvalid(arvalid), .M_AXI_arready(arready),
        .M_AXI_rdata(rdata),     .M_AXI_rresp(rresp),
        .M_AXI_rvalid(rvalid),   .M_AXI_rready(rready)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Slave configuration
    int          aw_lat = 0, w_lat = 0, ar_lat = 0;
    logic [63:0] slverr_mask = '0, corrupt_mask = '0;
    bit          never_ar = 1'b0;

    // Slave / monitor state
    logic [31:0] ram [64];
    logic [31:0] aw_log[$], w_log[$], ar_log[$];
    logic [31:0] aw_cap, w_cap, ar_cap;
    logic [31:0] p_awaddr, p_wdata, p_araddr;
    bit          aw_hs, w_hs, b_hs, ar_hs, r_hs;
    bit          pv_aw, pv_w, pv_ar;
    bit          aw_got, w_got;
    int          aw_wait, w_wait, ar_wait, wr_count, rd_count, inj_err;

    // Protocol monitor: sees the values the DUT sampled at this edge
    always @(posedge clk) begin
        if (!rst_n) begin
            pv_aw = 1'b0; pv_w = 1'b0; pv_ar = 1'b0;
        end else begin
            if (pv_aw) check("aw_hold", 64'({awvalid, awaddr}), 64'({1'b1, p_awaddr}));
            if (pv_w)  check("w_hold",  64'({wvalid, wdata}),   64'({1'b1, p_wdata}));
            if (pv_ar && !never_ar) check("ar_hold", 64'({arvalid, araddr}), 64'({1'b1, p_araddr}));
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            b_hs  = bvalid && bready;
            ar_hs = arvalid && arready;
            r_hs  = rvalid && rready;
            if (aw_hs) begin
                aw_log.push_back(awaddr); aw_cap = awaddr;
                check("awprot", 64'(awprot), 64'(0));
            end
            if (w_hs) begin
                w_log.push_back(wdata); w_cap = wdata;
                check("wstrb", 64'(wstrb), 64'(4'hF));
            end
            if (ar_hs) begin
                ar_log.push_back(araddr); ar_cap = araddr;
                check("arprot", 64'(arprot), 64'(0));
            end
            pv_aw = awvalid && !awready; p_awaddr = awaddr;
            pv_w  = wvalid && !wready;   p_wdata  = wdata;
            pv_ar = arvalid && !arready; p_araddr = araddr;
        end
    end

    // Behavioural slave RAM, updated away from the active edge
    always @(negedge clk) begin
        if (!rst_n) begin
            awready = 0; wready = 0; bvalid = 0; bresp = 0;
            arready = 0; rvalid = 0; rdata = 0; rresp = 0;
            aw_got = 0; w_got = 0; aw_wait = 0; w_wait = 0; ar_wait = 0;
            wr_count = 0; rd_count = 0; inj_err = 0;
            aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
            aw_log.delete(); w_log.delete(); ar_log.delete();
        end else begin
            if (aw_hs) begin aw_got = 1; awready = 0; aw_wait = 0; end
            if (w_hs)  begin w_got = 1;  wready = 0;  w_wait = 0;  end
            if (b_hs)  bvalid = 0;
            if (r_hs)  rvalid = 0;
            if (ar_hs) begin
                arready = 0; ar_wait = 0; rvalid = 1; rresp = RESP_OKAY;
                if (corrupt_mask[rd_count[5:0]]) begin rdata = 32'h0; inj_err++; end
                else rdata = ram[ar_cap[7:2]];
                rd_count++;
            end
            if (aw_got && w_got && !bvalid) begin
                ram[aw_cap[7:2]] = w_cap;
                bvalid = 1;
                if (slverr_mask[wr_count[5:0]]) begin bresp = 2'b10; inj_err++; end
                else bresp = RESP_OKAY;
                wr_count++;
                aw_got = 0; w_got = 0;
            end
            if (awvalid && !aw_got && !awready) begin
                if (aw_wait >= aw_lat) awready = 1; else aw_wait++;
            end
            if (wvalid && !w_got && !wready) begin
                if (w_wait >= w_lat) wready = 1; else w_wait++;
            end
            if (arvalid && !arready && !rvalid && !never_ar) begin
                if (ar_wait >= ar_lat) arready = 1; else ar_wait++;
            end
            aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
        end
    end

    typedef struct {
        string       name;
        int          aw_lat;
        int          w_lat;
        int          ar_lat;
        logic [63:0] slverr;
        logic [63:0] corrupt;
        bit          never_ar;
        int          exp_err;
    } vec_t;

    task automatic wait_done(input int budget, output int cycles, output bit ok);
        cycles = 0;
        while (dut.r_done !== 1'b1 && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        ok = (dut.r_done === 1'b1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".rst_valids"}, 64'({awvalid, wvalid, bready, arvalid, rready}), 64'(0));
        check({tag, ".rst_addr"},   64'({awaddr, araddr}), 64'(0));
        check({tag, ".rst_wdata"},  64'(wdata), 64'(0));
        check({tag, ".rst_err"},    64'(dut.r_err_cnt), 64'(0));
        check({tag, ".rst_done"},   64'(dut.r_done), 64'(0));
        check({tag, ".rst_state"},  64'(dut.r_state), 64'(WAIT));
    endtask

    function automatic logic [63:0] qget(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? 64'(q[i]) : 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    task automatic run_vec(input vec_t v);
        int cyc;
        bit ok;
        aw_lat = v.aw_lat; w_lat = v.w_lat; ar_lat = v.ar_lat;
        slverr_mask = v.slverr; corrupt_mask = v.corrupt; never_ar = v.never_ar;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state(v.name);
        rst_n = 1'b1;
        wait_done(4000, cyc, ok);
        check({v.name, ".done_reached"}, 64'(ok), 64'(1));
        repeat (5) @(negedge clk);
        check({v.name, ".err_cnt"}, 64'(dut.r_err_cnt), 64'(v.exp_err));
        check({v.name, ".done_held"}, 64'(dut.r_done), 64'(1));
        check({v.name, ".idle_outputs"}, 64'({awvalid, wvalid, bready, arvalid, rready}), 64'(0));
        check({v.name, ".aw_beats"}, 64'(aw_log.size()), 64'(NREG));
        check({v.name, ".w_beats"},  64'(w_log.size()),  64'(NREG));
        check({v.name, ".ar_beats"}, 64'(ar_log.size()), 64'(v.never_ar ? 0 : NREG));
        for (int i = 0; i < int'(NREG); i++) begin
            check($sformatf("%s.awaddr%0d", v.name, i), qget(aw_log, i), 64'(BASE + 32'(4 * i)));
            check($sformatf("%s.wdata%0d", v.name, i),  qget(w_log, i),  64'(32'hA5A5_0000 + 32'(i)));
            if (!v.never_ar)
                check($sformatf("%s.araddr%0d", v.name, i), qget(ar_log, i), 64'(BASE + 32'(4 * i)));
        end
        if (v.name == "zero_wait")
            check("zero_wait.latency_ok", 64'(cyc <= int'(SDLY + 8 * NREG + 4)), 64'(1));
        if (v.never_ar)
            check({v.name, ".timeout_len_ok"}, 64'(cyc >= int'(TMO)), 64'(1));
    endtask

    vec_t vecs[$];

    initial begin
        vec_t v;
        int cyc;
        bit ok;

        vecs.push_back('{"zero_wait",    0, 0, 0, 64'h0, 64'h0, 1'b0, 0});
        vecs.push_back('{"aw_first",     0, 3, 0, 64'h0, 64'h0, 1'b0, 0});
        vecs.push_back('{"w_first",      3, 0, 0, 64'h0, 64'h0, 1'b0, 0});
        vecs.push_back('{"corrupt_0x8",  0, 0, 0, 64'h0, 64'h4, 1'b0, 1});
        vecs.push_back('{"slverr_first", 0, 0, 0, 64'h1, 64'h0, 1'b0, 1});
        vecs.push_back('{"ar_never",     0, 0, 0, 64'h0, 64'h0, 1'b1, 1});
        vecs.push_back('{"both_errs",    1, 2, 1, 64'h8, 64'h3, 1'b0, 3});

        // Random latencies and injected errors; expected count is one per injected fault
        for (int k = 0; k < 12; k++) begin
            v.name     = $sformatf("rand%0d", k);
            v.aw_lat   = int'($urandom_range(0, 4));
            v.w_lat    = int'($urandom_range(0, 4));
            v.ar_lat   = int'($urandom_range(0, 4));
            v.slverr   = 64'($urandom_range(0, 15));
            v.corrupt  = 64'($urandom_range(0, 15));
            v.never_ar = 1'b0;
            v.exp_err  = $countones(v.slverr[3:0]) + $countones(v.corrupt[3:0]);
            vecs.push_back(v);
        end

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset while the second write is outstanding
        aw_lat = 0; w_lat = 4; ar_lat = 0;
        slverr_mask = '0; corrupt_mask = '0; never_ar = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        while (aw_log.size() < 2 && cyc < 500) begin @(negedge clk); cyc++; end
        check("midrst.second_aw_seen", 64'(aw_log.size()), 64'(2));
        check("midrst.second_awaddr", qget(aw_log, 1), 64'(BASE + 32'd4));
        check("midrst.w_pending", 64'(wvalid), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        check("midrst.valids_drop", 64'({awvalid, wvalid, bready, arvalid, rready}), 64'(0));
        check("midrst.state", 64'(dut.r_state), 64'(WAIT));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        while (aw_log.size() < 1 && cyc < 500) begin @(negedge clk); cyc++; end
        check("midrst.restart_awaddr", qget(aw_log, 0), 64'(BASE));
        wait_done(4000, cyc, ok);
        check("midrst.done_reached", 64'(ok), 64'(1));
        check("midrst.err_cnt", 64'(dut.r_err_cnt), 64'(0));
        check("midrst.aw_beats", 64'(aw_log.size()), 64'(NREG));
        check("midrst.restart_wdata0", qget(w_log, 0), 64'(32'hA5A5_0000));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
